wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter sitting directly upstream of the register file's write port. It merges results from the ALU and the load/store unit (LSU) into the file's single write port and buffers ALU results in a small FIFO while the LSU holds the port. It publishes a pending-write mask to the issue/hazard logic. Every write reaches the register file through a registered port one cycle after it is selected.

## Interface
Parameters:
- XLEN, 64, datapath width; must match the register file.
- ALU_DEPTH, 2, ALU result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4, consecutive LSU grants with a non-empty FIFO before the LSU is throttled for one cycle.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  load result offered.
- lsu_ready  out  1  load result accepted this cycle when high with lsu_valid.
- lsu_rd  in  5  load destination register.
- lsu_data  in  XLEN  load result.
- rf_we  out  1  register-file write enable (registered).
- rf_rd  out  5  register-file write address (registered).
- rf_wd  out  XLEN  register-file write data (registered).
- pend_mask  out  32  bit i set while a write to xi is buffered or on rf_* this cycle; bit 0 is always 0.

## Operation
- Handshake: a transfer occurs when valid and ready are both high at a rising edge. Offered rd and data hold stable until the transfer.
- alu_ready = !fifo_full. lsu_ready = !throttle.
- Writes with rd == 0 are accepted and silently dropped. They are never enqueued, never drive rf_we, and never set pend_mask.
- Per-cycle selection of the write to launch, in priority order:
  1. an accepted LSU result;
  2. the FIFO head;
  3. an accepted ALU result when the FIFO is empty (bypass).
- An accepted ALU result that is not launched is enqueued at the FIFO tail.
- Same cycle, FIFO non-empty: a head pop and a tail push are both allowed. A push when full cannot occur because alu_ready is low.
- Starvation counter: increments on each cycle where the LSU wins while the FIFO is non-empty, and resets to 0 on any cycle the FIFO head is launched.
  - When the counter reaches STARVE_LIMIT, throttle = 1 for exactly the next cycle. The head is launched in that cycle, and the counter then clears.
- rf_we/rf_rd/rf_wd register the launched write. rf_we = 0 in any cycle with no launch.
- Ordering: the issue stage must not issue a producer whose rd has its pend_mask bit set. The bench asserts that the LSU never offers an rd matching a FIFO entry.

## Timing
- Reset values: rf_we = 0, rf_rd = 0, rf_wd = 0, FIFO empty, counter = 0, throttle = 0, pend_mask = 0. While reset is high, no transfers are accepted.
- Latency from acceptance to rf_we:
  - LSU: 1 cycle.
  - ALU with bypass: 1 cycle.
  - Buffered ALU: 1 cycle after reaching the head with no LSU grant.
- alu_ready, lsu_ready and pend_mask are combinational from registered state only. They have no path from the valid inputs.
- Reset asserted mid-operation: buffered writes are discarded and rf_we drops asynchronously.

## Structure
- Package wb_pkg holds:
  - typedef wb_entry_t {logic [4:0] rd; logic [XLEN-1:0] data;}, with XLEN taken from a package parameter;
  - the default STARVE_LIMIT localparam.
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t with push/pop/full/empty and a per-entry valid vector, used to build pend_mask. It uses wrap-around pointers with an extra bit for full/empty detection.

## Test plan
- ALU only, FIFO empty: alu_rd=5, data=0x1234 accepted at cycle N -> rf_we=1, rf_rd=5, rf_wd=0x1234 at N+1; pend_mask[5] is set only during N+1.
- LSU and ALU in the same cycle (lsu rd=3, alu rd=7) -> rd=3 written at N+1, rd=7 at N+2; pend_mask[7] is high during N+1 and N+2.
- Fill the FIFO: two ALU results accepted while lsu_valid is held high -> alu_ready=0 from the next cycle. The LSU is throttled after 4 wins, the head drains, and alu_ready returns to 1.
- rd=0 writes on both ports -> accepted, rf_we stays 0, pend_mask stays 0.
- Reset asserted with 2 buffered entries -> rf_we=0 immediately, FIFO empty, no buffered write appears after reset releases.
- Pointer wrap: 10 back-to-back buffered ALU writes with alternating LSU traffic -> all appear on rf_* in acceptance order with correct data.

Source files
------------

// File: rtl/wb_pkg.sv
// Writeback arbiter shared types.
// Entry layout and defaults for the register-file write path.
package wb_pkg;

  localparam int XLEN = 64;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  function automatic logic [31:0] rd_bit(
    input logic [4:0] rd
  );
    return 32'd1 << rd;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// ALU result FIFO for the writeback arbiter.
// Extra pointer bit separates full from empty; vld tracks live slots.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             wdata,
  input  logic                  pop,
  output wb_entry_t             rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      vld,
  output logic [DEPTH-1:0][4:0] rds
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PONE = (AW+1)'(1);

  logic [AW:0]      wp_q;
  logic [AW:0]      rp_q;
  logic [DEPTH-1:0] vld_q;
  logic             do_push;
  logic             do_pop;
  wb_entry_t        mem [DEPTH];

  assign empty = wp_q == rp_q;
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign rdata = mem[rp_q[AW-1:0]];
  assign vld   = vld_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_rd
    assign rds[i] = mem[i].rd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      vld_q <= '0;
    end else begin
      if (do_push) begin
        wp_q                 <= wp_q + PONE;
        vld_q[wp_q[AW-1:0]]  <= 1'b1;
      end
      if (do_pop) begin
        rp_q                 <= rp_q + PONE;
        vld_q[rp_q[AW-1:0]]  <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset; vld_q gates every use.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges LSU and ALU results onto the RF port.
// LSU first, then buffered ALU head, then ALU bypass.
module wb_arbiter #(
  parameter int XLEN         = 64,
  parameter int ALU_DEPTH    = 2,
  parameter int STARVE_LIMIT = wb_pkg::STARVE_LIMIT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic [31:0]     pend_mask
);

  import wb_pkg::*;

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] ONE = CW'(1);

  wb_entry_t alu_e;
  wb_entry_t lsu_e;
  wb_entry_t head;
  wb_entry_t launch_e;

  logic full;
  logic empty;
  logic throttle;
  logic alu_fire;
  logic lsu_fire;
  logic alu_live;
  logic lsu_live;
  logic sel_lsu;
  logic sel_head;
  logic sel_byp;
  logic launch;
  logic push;
  logic pop;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic [ALU_DEPTH-1:0]      vld;
  logic [ALU_DEPTH-1:0][4:0] rds;

  assign throttle  = cnt_q >= LIM;
  assign alu_ready = !reset && !full;
  assign lsu_ready = !reset && !throttle;

  assign alu_fire = alu_valid && alu_ready;
  assign lsu_fire = lsu_valid && lsu_ready;

  // rd == 0 is accepted but never competes for the port.
  assign alu_live = alu_fire && (alu_rd != 5'd0);
  assign lsu_live = lsu_fire && (lsu_rd != 5'd0);

  assign alu_e = '{rd: alu_rd, data: alu_data};
  assign lsu_e = '{rd: lsu_rd, data: lsu_data};

  assign sel_lsu  = lsu_live;
  assign sel_head = !lsu_live && !empty;
  assign sel_byp  = !lsu_live && empty && alu_live;

  assign launch = sel_lsu || sel_head || sel_byp;
  assign push   = alu_live && !sel_byp;
  assign pop    = sel_head;

  always_comb begin
    launch_e = '0;
    unique case (1'b1)
      sel_lsu:  launch_e = lsu_e;
      sel_head: launch_e = head;
      sel_byp:  launch_e = alu_e;
      default:  launch_e = '0;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pop) begin
      cnt_d = '0;
    end else if (sel_lsu && !empty && cnt_q != LIM) begin
      cnt_d = cnt_q + ONE;
    end
  end

  wb_fifo #(
    .DEPTH (ALU_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (alu_e),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .vld   (vld),
    .rds   (rds)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else begin
      cnt_q <= cnt_d;
      rf_we <= launch;
      if (launch) begin
        rf_rd <= launch_e.rd;
        rf_wd <= launch_e.data;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < ALU_DEPTH; i++) begin
      if (vld[i]) begin
        pend_mask = pend_mask | rd_bit(rds[i]);
      end
    end
    if (rf_we) begin
      pend_mask = pend_mask | rd_bit(rf_rd);
    end
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed steps with a transaction model
// feeding an expected-write queue checked against rf_*.
module tb_wb_arbiter;

  import wb_pkg::*;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [63:0] rf_wd;
  logic [31:0] pend_mask;

  int total = 0;
  int bad   = 0;

  wb_entry_t mq[$];
  wb_entry_t exp_q[$];
  int        mcnt = 0;

  bit fa;
  bit fl;

  wb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .pend_mask (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] want
  );
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  // One clock: predict launch, push expectation, compare after edge.
  task automatic tick(output bit ta, output bit tl);
    wb_entry_t   ae;
    wb_entry_t   le;
    wb_entry_t   ln;
    bit          la;
    bit          ll;
    bit          go;
    bit          hit;
    bit          thr;
    logic [31:0] pm;
    thr = mcnt >= 4;
    chk("alu_ready", alu_ready, mq.size() < 2);
    chk("lsu_ready", lsu_ready, !thr);
    hit = 1'b0;
    if (lsu_valid && lsu_rd != 0)
      foreach (mq[i]) if (mq[i].rd == lsu_rd) hit = 1'b1;
    if (lsu_valid) chk("lsu_hazard", hit, 0);
    ta = alu_valid && (mq.size() < 2);
    tl = lsu_valid && !thr;
    ae = '{rd: alu_rd, data: alu_data};
    le = '{rd: lsu_rd, data: lsu_data};
    la = ta && alu_rd != 0;
    ll = tl && lsu_rd != 0;
    ln = '0;
    go = 1'b1;
    if (ll) begin
      ln = le;
      if (mq.size() > 0) mcnt++;
    end else if (mq.size() > 0) begin
      ln = mq.pop_front();
      mcnt = 0;
    end else if (la) begin
      ln = ae;
      la = 1'b0;
    end else begin
      go = 1'b0;
    end
    if (la) mq.push_back(ae);
    if (go) exp_q.push_back(ln);
    pm = '0;
    foreach (mq[i]) pm[mq[i].rd] = 1'b1;
    if (go) pm[ln.rd] = 1'b1;
    pm[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("rf_we", rf_we, go);
    if (rf_we && exp_q.size() > 0) begin
      ln = exp_q.pop_front();
      chk("rf_rd", rf_rd, ln.rd);
      chk("rf_wd", rf_wd, ln.data);
    end else begin
      exp_q.delete();
    end
    chk("pend_mask", pend_mask, pm);
  endtask

  task automatic idle(input int n);
    bit a;
    bit l;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    repeat (n) tick(a, l);
  endtask

  // Offer on either port and hold until accepted.
  task automatic offer(
    input bit          av,
    input logic [4:0]  ard,
    input logic [63:0] ad,
    input bit          lv,
    input logic [4:0]  lrd,
    input logic [63:0] ld
  );
    bit pa;
    bit pl;
    bit a;
    bit l;
    int n;
    pa = av;
    pl = lv;
    n  = 0;
    while ((pa || pl) && n < 16) begin
      alu_valid = pa;
      alu_rd    = ard;
      alu_data  = ad;
      lsu_valid = pl;
      lsu_rd    = lrd;
      lsu_data  = ld;
      tick(a, l);
      if (a) pa = 1'b0;
      if (l) pl = 1'b0;
      n++;
    end
    chk("offer_timeout", pa || pl, 0);
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
  endtask

  initial begin
    int lr;
    int thr_seen;
    int ai;
    int lk;
    int cyc;
    reset     = 1'b1;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    lsu_valid = 1'b0;
    lsu_rd    = '0;
    lsu_data  = '0;
    #12;
    chk("rst_we", rf_we, 0);
    chk("rst_rd", rf_rd, 0);
    chk("rst_wd", rf_wd, 0);
    chk("rst_pend", pend_mask, 0);
    chk("rst_alu_rdy", alu_ready, 0);
    chk("rst_lsu_rdy", lsu_ready, 0);
    reset = 1'b0;
    #1;

    // ALU bypass
    offer(1, 5'd5, 64'h1234, 0, 5'd0, 64'h0);
    chk("byp_we", rf_we, 1);
    chk("byp_rd", rf_rd, 5);
    chk("byp_wd", rf_wd, 64'h1234);
    chk("byp_pend", pend_mask, 32'h20);
    idle(1);
    chk("byp_pend_clr", pend_mask, 0);

    // LSU and ALU collide
    offer(1, 5'd7, 64'h77, 1, 5'd3, 64'h33);
    chk("col_rd1", rf_rd, 3);
    chk("col_pend1", pend_mask, 32'h88);
    idle(1);
    chk("col_rd2", rf_rd, 7);
    chk("col_wd2", rf_wd, 64'h77);
    chk("col_pend2", pend_mask, 32'h80);
    idle(1);
    chk("col_pend3", pend_mask, 0);

    // Fill FIFO under a continuous LSU stream
    alu_valid = 1'b1;
    alu_rd    = 5'd10;
    alu_data  = 64'hA10;
    lsu_valid = 1'b1;
    lsu_rd    = 5'd20;
    lsu_data  = 64'hB20;
    tick(fa, fl);
    alu_rd   = 5'd11;
    alu_data = 64'hA11;
    lsu_rd   = 5'd21;
    lsu_data = 64'hB21;
    tick(fa, fl);
    alu_valid = 1'b0;
    chk("fill_full", alu_ready, 0);
    lr       = 22;
    thr_seen = 0;
    cyc      = 0;
    while (lr < 32 && cyc < 40) begin
      lsu_valid = 1'b1;
      lsu_rd    = 5'(lr);
      lsu_data  = 64'hB00 + 64'(lr);
      if (!lsu_ready) thr_seen++;
      tick(fa, fl);
      if (fl) lr++;
      cyc++;
    end
    chk("starve_timeout", lr, 32);
    chk("throttles", thr_seen, 2);
    idle(2);
    chk("drain_rdy", alu_ready, 1);

    // rd 0 on both ports
    offer(1, 5'd0, 64'hDEAD, 1, 5'd0, 64'hBEEF);
    chk("x0_we", rf_we, 0);
    chk("x0_pend", pend_mask, 0);
    idle(1);

    // Reset with two buffered entries
    offer(1, 5'd13, 64'hC13, 1, 5'd12, 64'hC12);
    offer(1, 5'd15, 64'hC15, 1, 5'd14, 64'hC14);
    chk("pre_rst_full", alu_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_we", rf_we, 0);
    chk("arst_pend", pend_mask, 0);
    chk("arst_alu_rdy", alu_ready, 0);
    mq.delete();
    exp_q.delete();
    mcnt = 0;
    @(posedge clk);
    #1;
    chk("rst_hold_we", rf_we, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("post_rst_rdy", alu_ready, 1);
    idle(3);

    // Pointer wrap with alternating LSU traffic
    ai  = 0;
    lk  = 0;
    cyc = 0;
    while (ai < 10 && cyc < 60) begin
      alu_valid = 1'b1;
      alu_rd    = 5'(ai + 1);
      alu_data  = 64'hA5A5_0000_0000_0000 | 64'(ai);
      lsu_valid = (cyc % 2) == 0;
      lsu_rd    = 5'(16 + (lk % 16));
      lsu_data  = 64'h5A5A_0000_0000_0000 | 64'(lk);
      tick(fa, fl);
      if (fa) ai++;
      if (fl) lk++;
      cyc++;
    end
    chk("wrap_timeout", ai, 10);
    idle(4);
    chk("wrap_pend", pend_mask, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
